// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and sample-code helper for the DDS DAC path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

    localparam int         SAMPLE_W             = 16;
    localparam int         DAC_FRAME_W          = 24;
    localparam logic [7:0] DAC_CMD_WRITE_UPDATE = 8'h30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    // Two's complement to offset binary: flipping the sign bit maps
    // -32768 -> 0x0000, 0 -> 0x8000, 32767 -> 0xFFFF.
    function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
        return s ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/dds_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; head word is read straight from the storage flops.
// Latency: a word pushed at edge N is visible on o_head_dat after edge N (no write-through bypass).
// Backpressure: pushes while full and pops while empty are ignored; o_full drives upstream ready.
// Ports: i_push/i_push_dat write side, i_pop/o_head_dat read side, o_full/o_empty/o_level status.
module dds_sample_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 16,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_level == LW'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    // Storage needs no reset: it is only observed through the level count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/dds_dac_serializer.sv
// Buffers signed samples and shifts each out MSB-first as a 24-bit {cmd, data} SPI DAC frame.
// Latency: pop one cycle after push into an empty FIFO, cs_n falls the cycle after the pop;
//          frame period is 1 + 48*CLK_DIV + CS_GAP cycles.
// Backpressure: s_tready = FIFO not full (combinational from level); upstream stalls while the DAC link drains.
// Ports: s_t* sample stream in, dac_sclk/dac_cs_n/dac_mosi SPI out, fifo_level/busy status.
module dds_dac_serializer
    import dds_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 4,
    parameter int         CLK_DIV       = 2,
    parameter int         CS_GAP        = 2,
    parameter logic [7:0] DAC_CMD       = DAC_CMD_WRITE_UPDATE,
    parameter bit         OFFSET_BINARY = 1'b1,
    localparam int        LVL_W         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic                dac_sclk,
    output logic                dac_cs_n,
    output logic                dac_mosi,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                busy
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int BIT_W = $clog2(DAC_FRAME_W);

    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DAC_FRAME_W - 1);

    // FIFO interface
    logic [SAMPLE_W-1:0]    w_head_dat;
    logic [SAMPLE_W-1:0]    w_data;
    logic [DAC_FRAME_W-1:0] w_frame_load;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;

    // Serializer state. r_frame holds only the bits not yet on mosi,
    // so the next bit to send is always r_frame[MSB].
    ser_state_t             r_state;
    logic [DAC_FRAME_W-2:0] r_frame;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DIV_W-1:0]       r_div;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   r_cs_n;
    logic                   r_sclk;
    logic                   r_mosi;

    ser_state_t             w_state_nxt;
    logic [DAC_FRAME_W-2:0] w_frame_nxt;
    logic [BIT_W-1:0]       w_bit_nxt;
    logic [DIV_W-1:0]       w_div_nxt;
    logic [GAP_W-1:0]       w_gap_nxt;
    logic                   w_cs_n_nxt;
    logic                   w_sclk_nxt;
    logic                   w_mosi_nxt;

    dds_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (s_tvalid),
        .i_push_dat (s_tdata),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (fifo_level)
    );

    assign w_data       = OFFSET_BINARY ? to_offset_binary(w_head_dat) : w_head_dat;
    assign w_frame_load = {DAC_CMD, w_data};

    assign s_tready = !w_full;
    assign dac_sclk = r_sclk;
    assign dac_cs_n = r_cs_n;
    assign dac_mosi = r_mosi;
    // The launch (pop) cycle is counted as busy so busy spans the whole frame period.
    assign busy     = (r_state != IDLE) || w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_div     <= '0;
            r_gap_cnt <= '0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_div     <= w_div_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_bit_nxt   = r_bit_cnt;
        w_div_nxt   = r_div;
        w_gap_nxt   = r_gap_cnt;
        w_cs_n_nxt  = r_cs_n;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_pop       = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_cs_n_nxt = 1'b1;
                w_sclk_nxt = 1'b0;
                w_mosi_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_frame_nxt = w_frame_load[DAC_FRAME_W-2:0];
                    w_mosi_nxt  = w_frame_load[DAC_FRAME_W-1];
                    w_bit_nxt   = BIT_TOP;
                    w_div_nxt   = '0;
                    w_cs_n_nxt  = 1'b0;
                    w_state_nxt = SHIFT;
                end
            end

            // Each bit: CLK_DIV cycles sclk low (setup), CLK_DIV cycles sclk high.
            // mosi only moves together with the falling sclk edge.
            SHIFT: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (r_div == DIV_RISE) begin
                    w_sclk_nxt = 1'b1;
                end
                if (r_div == DIV_LAST) begin
                    w_sclk_nxt = 1'b0;
                    w_div_nxt  = '0;
                    if (r_bit_cnt == '0) begin
                        w_cs_n_nxt  = 1'b1;
                        w_mosi_nxt  = 1'b0;
                        w_gap_nxt   = '0;
                        w_state_nxt = GAP;
                    end else begin
                        w_bit_nxt   = r_bit_cnt - BIT_W'(1);
                        w_mosi_nxt  = r_frame[DAC_FRAME_W-2];
                        w_frame_nxt = {r_frame[DAC_FRAME_W-3:0], 1'b0};
                    end
                end
            end

            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cs_n_nxt  = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_mosi_nxt  = 1'b0;
            end
        endcase
    end

endmodule
